// File: rtl/tpu_pkg.sv
// Shared types and helpers for the systolic-array result drain.
// Holds the drain FSM states, saturation limits and beat counting.
package tpu_pkg;

  typedef enum logic {
    IDLE,
    DRAIN
  } drain_state_e;

  localparam int SAT_MAX = 127;
  localparam int SAT_MIN = -128;

  function automatic int unsigned beats_per_frame(
    input int unsigned dim,
    input int unsigned acc_w,
    input int unsigned out_w,
    input logic        narrow
  );
    return narrow ? dim * dim : dim * dim * (acc_w / out_w);
  endfunction

endpackage

// File: rtl/tpu_elem_postproc.sv
// Per-element capture-path processing: optional ReLU, then
// optional saturation to a signed byte (zero-extended).
module tpu_elem_postproc
  import tpu_pkg::*;
#(
  parameter int ACC_W = 16
) (
  input  logic [ACC_W-1:0] acc_i,
  input  logic             relu_i,
  input  logic             narrow_i,
  output logic [ACC_W-1:0] elem_o
);

  localparam logic signed [ACC_W-1:0] HI = ACC_W'(SAT_MAX);
  localparam logic signed [ACC_W-1:0] LO = ACC_W'(SAT_MIN);

  logic signed [ACC_W-1:0] v;
  logic [7:0]              sat;

  always_comb begin
    v = acc_i;
    if (relu_i && acc_i[ACC_W-1]) v = '0;
    sat = v[7:0];
    if (v > HI) sat = HI[7:0];
    else if (v < LO) sat = LO[7:0];
    elem_o = narrow_i ? {{(ACC_W-8){1'b0}}, sat} : v;
  end

endmodule

// File: rtl/tpu_result_drain.sv
// Double-buffered readout of a DIM x DIM accumulator frame,
// streamed as OUT_W-bit beats over valid/ready.
module tpu_result_drain
  import tpu_pkg::*;
#(
  parameter int DIM   = 2,
  parameter int ACC_W = 16,
  parameter int OUT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     capture,
  input  logic [DIM*DIM*ACC_W-1:0] acc_flat,
  input  logic                     col_major,
  input  logic                     relu,
  input  logic                     narrow,
  output logic [OUT_W-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     pending_full,
  output logic                     overflow
);

  localparam int unsigned ELEMS = DIM * DIM;
  localparam int unsigned BPE   = ACC_W / OUT_W;
  localparam int unsigned BFULL = ELEMS * BPE;
  localparam int          CW    = $clog2(BFULL + 1);
  localparam int          IW    = $clog2(ELEMS);
  localparam int unsigned UDIM  = DIM;

  drain_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pfull_q, pfull_d;
  logic          ovf_q, ovf_d;

  logic [ACC_W-1:0] cap_elem [ELEMS];
  logic [ACC_W-1:0] drain_q  [ELEMS];
  logic [ACC_W-1:0] pend_q   [ELEMS];
  logic             dcol_q, dnar_q;
  logic             pcol_q, pnar_q;

  logic          ld_dcap, ld_dpend, ld_pcap;
  logic          hs, last;
  logic [CW-1:0] last_idx;

  for (genvar i = 0; i < ELEMS; i++) begin : g_pp
    tpu_elem_postproc #(
      .ACC_W (ACC_W)
    ) u_pp (
      .acc_i    (acc_flat[i*ACC_W +: ACC_W]),
      .relu_i   (relu),
      .narrow_i (narrow),
      .elem_o   (cap_elem[i])
    );
  end

  assign last_idx = CW'(beats_per_frame(DIM, ACC_W, OUT_W, dnar_q) - 1);
  assign out_valid    = (state_q == DRAIN);
  assign last         = (cnt_q == last_idx);
  assign out_last     = out_valid && last;
  assign hs           = out_valid && out_ready;
  assign pending_full = pfull_q;
  assign overflow     = ovf_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pfull_d  = pfull_q;
    ovf_d    = ovf_q;
    ld_dcap  = 1'b0;
    ld_dpend = 1'b0;
    ld_pcap  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (capture) begin
          ld_dcap = 1'b1;
          cnt_d   = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (hs) cnt_d = cnt_q + 1'b1;
        if (hs && last) begin
          cnt_d = '0;
          // Pending frame wins the drain bank; a same-cycle
          // capture then refills pending instead of dropping.
          if (pfull_q) begin
            ld_dpend = 1'b1;
            ld_pcap  = capture;
            pfull_d  = capture;
          end else if (capture) begin
            ld_dcap = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (capture) begin
          if (pfull_q) begin
            ovf_d = 1'b1;
          end else begin
            ld_pcap = 1'b1;
            pfull_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pfull_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pfull_q <= pfull_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ELEMS; i++) begin
        drain_q[i] <= '0;
        pend_q[i]  <= '0;
      end
      dcol_q <= 1'b0;
      dnar_q <= 1'b0;
      pcol_q <= 1'b0;
      pnar_q <= 1'b0;
    end else begin
      if (ld_dcap) begin
        drain_q <= cap_elem;
        dcol_q  <= col_major;
        dnar_q  <= narrow;
      end else if (ld_dpend) begin
        drain_q <= pend_q;
        dcol_q  <= pcol_q;
        dnar_q  <= pnar_q;
      end
      if (ld_pcap) begin
        pend_q <= cap_elem;
        pcol_q <= col_major;
        pnar_q <= narrow;
      end
    end
  end

  int unsigned      pos, byt, idx;
  logic [ACC_W-1:0] elem;
  logic [OUT_W-1:0] beat;

  // Byte 0 of an element in stream order is its MSB byte.
  always_comb begin
    pos = dnar_q ? 32'(cnt_q) : 32'(cnt_q) / BPE;
    byt = dnar_q ? 0 : BPE - 1 - (32'(cnt_q) % BPE);
    idx = dcol_q ? (pos % UDIM) * UDIM + pos / UDIM : pos;
    elem = drain_q[IW'(idx)];
    beat = OUT_W'(elem >> (byt * OUT_W));
    out_data = out_valid ? beat : '0;
  end

endmodule

// File: tb/tb_tpu_result_drain.sv
// Directed checks of tpu_result_drain with DIM=2, ACC_W=16, OUT_W=8.
// Inputs change and outputs are sampled on the falling edge.
module tb_tpu_result_drain;

  logic        clk;
  logic        rst;
  logic        capture;
  logic [63:0] acc_flat;
  logic        col_major;
  logic        relu;
  logic        narrow;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        pending_full;
  logic        overflow;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [63:0] FA = {16'h7FFF, 16'h0304, 16'hFF80, 16'h0102};
  localparam logic [63:0] FB = {16'h7788, 16'h5566, 16'h3344, 16'h1122};
  localparam logic [63:0] FC = {16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};

  tpu_result_drain #(
    .DIM   (2),
    .ACC_W (16),
    .OUT_W (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .capture      (capture),
    .acc_flat     (acc_flat),
    .col_major    (col_major),
    .relu         (relu),
    .narrow       (narrow),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .pending_full (pending_full),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_frame(input string tag, input logic [7:0] e[$]);
    out_ready = 1'b1;
    for (int i = 0; i < e.size(); i++) begin
      chk({tag, " valid"}, 32'(out_valid), 32'd1);
      chk({tag, " data"}, 32'(out_data), 32'(e[i]));
      chk({tag, " last"}, 32'(out_last), 32'(i == e.size() - 1));
      @(negedge clk);
    end
    chk({tag, " idle"}, 32'(out_valid), 32'd0);
  endtask

  task automatic start(input logic [63:0] a, input logic cm,
                       input logic rl, input logic nr);
    acc_flat  = a;
    col_major = cm;
    relu      = rl;
    narrow    = nr;
    capture   = 1'b1;
    @(negedge clk);
    capture = 1'b0;
  endtask

  logic [7:0] row_a[$];
  logic [7:0] col_a[$];
  logic [7:0] row_b[$];
  logic [7:0] exp5[$];

  initial begin
    row_a = '{8'h01, 8'h02, 8'hFF, 8'h80, 8'h03, 8'h04, 8'h7F, 8'hFF};
    col_a = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hFF, 8'h80, 8'h7F, 8'hFF};
    row_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

    rst = 1'b1;
    capture = 1'b1;
    acc_flat = FA;
    col_major = 1'b0;
    relu = 1'b0;
    narrow = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset valid", 32'(out_valid), 32'd0);
    chk("reset last", 32'(out_last), 32'd0);
    chk("reset data", 32'(out_data), 32'd0);
    chk("reset pend", 32'(pending_full), 32'd0);
    chk("reset ovf", 32'(overflow), 32'd0);
    rst = 1'b0;
    capture = 1'b0;
    @(negedge clk);
    chk("post-reset idle", 32'(out_valid), 32'd0);

    start(FA, 1'b0, 1'b0, 1'b0);
    run_frame("row", row_a);

    start(FA, 1'b1, 1'b0, 1'b0);
    run_frame("col", col_a);

    start(FA, 1'b0, 1'b0, 1'b1);
    run_frame("narrow", '{8'h7F, 8'h80, 8'h7F, 8'h7F});

    start(FA, 1'b0, 1'b1, 1'b1);
    run_frame("narrow relu", '{8'h7F, 8'h00, 8'h7F, 8'h7F});

    // Backpressure: ready pattern 1,0,0,1 repeating.
    start(FA, 1'b0, 1'b0, 1'b0);
    begin
      int got = 0;
      int cyc = 0;
      while (got < 8 && cyc < 40) begin
        out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        chk("bp valid", 32'(out_valid), 32'd1);
        chk("bp data", 32'(out_data), 32'(row_a[got]));
        chk("bp last", 32'(out_last), 32'(got == 7));
        if (out_ready) got++;
        cyc++;
        @(negedge clk);
      end
      chk("bp beats", 32'(got), 32'd8);
      chk("bp idle", 32'(out_valid), 32'd0);
    end
    out_ready = 1'b1;

    // Double buffer: A at 0, B at 2, C at 4 (dropped), D=A at 16.
    exp5 = {row_a, row_b, row_a};
    start(FA, 1'b0, 1'b0, 1'b0);
    for (int j = 1; j <= 25; j++) begin
      chk("db valid", 32'(out_valid), 32'(j <= 24));
      if (j <= 24) begin
        chk("db data", 32'(out_data), 32'(exp5[j-1]));
        chk("db last", 32'(out_last),
            32'(j == 8 || j == 16 || j == 24));
      end
      chk("db pend", 32'(pending_full), 32'(j >= 3 && j <= 8));
      chk("db ovf", 32'(overflow), 32'(j >= 5));
      capture = 1'b0;
      if (j == 2) begin capture = 1'b1; acc_flat = FB; end
      if (j == 4) begin capture = 1'b1; acc_flat = FC; end
      if (j == 16) begin capture = 1'b1; acc_flat = FA; end
      @(negedge clk);
    end
    capture = 1'b0;

    // Reset mid-drain with pending full and overflow set.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start(FA, 1'b0, 1'b0, 1'b0);
    chk("rm beat1", 32'(out_data), 32'h01);
    acc_flat = FB;
    capture = 1'b1;
    @(negedge clk);
    chk("rm beat2", 32'(out_data), 32'h02);
    chk("rm pend", 32'(pending_full), 32'd1);
    acc_flat = FC;
    @(negedge clk);
    chk("rm beat3", 32'(out_data), 32'hFF);
    chk("rm ovf set", 32'(overflow), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rm valid", 32'(out_valid), 32'd0);
    chk("rm pend clr", 32'(pending_full), 32'd0);
    chk("rm ovf clr", 32'(overflow), 32'd0);
    chk("rm data", 32'(out_data), 32'd0);
    rst = 1'b0;
    capture = 1'b0;
    start(FA, 1'b0, 1'b0, 1'b0);
    run_frame("fresh", row_a);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
